// File: rtl/ptc_hdr_inserter_upto96bits.sv
// Prepends a 0-3 DWORD header to every single-region MFB frame; TX outputs are registered.
// Defining PTC_HDR_INSERTER_FRAME_CNT_EN adds the FRAME_CNT output (count of transmitted frame ends).
module ptc_hdr_inserter_upto96bits #(
  parameter int BLOCK_SIZE = 8,
  parameter int ITEM_WIDTH = 32
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [BLOCK_SIZE*ITEM_WIDTH-1:0]   RX_DATA,
  input  logic                               RX_SOF,
  input  logic                               RX_EOF,
  input  logic [$clog2(BLOCK_SIZE)-1:0]      RX_EOF_POS,
  input  logic [3*ITEM_WIDTH-1:0]            RX_HDR_DATA,
  input  logic [1:0]                         RX_HDR_LEN,
  input  logic                               RX_SRC_RDY,
  output logic                               RX_DST_RDY,
  output logic [BLOCK_SIZE*ITEM_WIDTH-1:0]   TX_DATA,
  output logic                               TX_SOF,
  output logic                               TX_EOF,
  output logic [$clog2(BLOCK_SIZE)-1:0]      TX_EOF_POS,
  output logic                               TX_SRC_RDY,
  input  logic                               TX_DST_RDY
`ifdef PTC_HDR_INSERTER_FRAME_CNT_EN
  ,output logic [31:0]                       FRAME_CNT
`endif
);

  localparam int DW = BLOCK_SIZE*ITEM_WIDTH;
  localparam int EW = $clog2(BLOCK_SIZE);
  localparam int CW = 3*ITEM_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_FRAME = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      s_r, shift_s;
  logic [CW-1:0]   carry_r, carry_nxt_s, prefix_s;
  logic [DW-1:0]   shifted_s, tx_data_r;
  logic [EW:0]     eof_sum_s;
  logic [EW-1:0]   flush_pos_r, tx_eof_pos_r;
  logic            need_flush_s, out_free_s, rx_dst_rdy_s, rx_xfer_s;
  logic            tx_sof_r, tx_eof_r, tx_src_rdy_r;

  assign out_free_s   = !tx_src_rdy_r || TX_DST_RDY;
  assign rx_dst_rdy_s = out_free_s && (state_r != ST_FLUSH);
  assign rx_xfer_s    = RX_SRC_RDY && rx_dst_rdy_s;

  // Shift the RX word up by S items, filling the gap with header (SOF) or carried items.
  always_comb begin
    shift_s      = RX_SOF ? RX_HDR_LEN : s_r;
    prefix_s     = RX_SOF ? RX_HDR_DATA : carry_r;
    eof_sum_s    = {1'b0, RX_EOF_POS} + {{(EW-1){1'b0}}, shift_s};
    need_flush_s = eof_sum_s[EW];
    shifted_s    = RX_DATA;
    carry_nxt_s  = {CW{1'b0}};
    case (shift_s)
      2'd1: begin
        shifted_s   = {RX_DATA[DW-ITEM_WIDTH-1:0], prefix_s[ITEM_WIDTH-1:0]};
        carry_nxt_s = {{(2*ITEM_WIDTH){1'b0}}, RX_DATA[DW-1 -: ITEM_WIDTH]};
      end
      2'd2: begin
        shifted_s   = {RX_DATA[DW-2*ITEM_WIDTH-1:0], prefix_s[2*ITEM_WIDTH-1:0]};
        carry_nxt_s = {{ITEM_WIDTH{1'b0}}, RX_DATA[DW-1 -: 2*ITEM_WIDTH]};
      end
      2'd3: begin
        shifted_s   = {RX_DATA[DW-3*ITEM_WIDTH-1:0], prefix_s};
        carry_nxt_s = RX_DATA[DW-1 -: CW];
      end
      default: begin
        shifted_s   = RX_DATA;
        carry_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // Frame-tracking next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_xfer_s && RX_SOF) begin
          if (RX_EOF) state_nxt_s = need_flush_s ? ST_FLUSH : ST_IDLE;
          else        state_nxt_s = ST_IN_FRAME;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_IN_FRAME: begin
        if (rx_xfer_s && RX_EOF) state_nxt_s = need_flush_s ? ST_FLUSH : ST_IDLE;
        else                     state_nxt_s = ST_IN_FRAME;
      end
      ST_FLUSH: begin
        if (out_free_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Output register, shift amount and carried items; a flush beat emits only the carry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_data_r    <= {DW{1'b0}};
      tx_sof_r     <= 1'b0;
      tx_eof_r     <= 1'b0;
      tx_eof_pos_r <= {EW{1'b0}};
      tx_src_rdy_r <= 1'b0;
      s_r          <= 2'd0;
      carry_r      <= {CW{1'b0}};
      flush_pos_r  <= {EW{1'b0}};
    end else if (rx_xfer_s) begin
      tx_data_r    <= shifted_s;
      tx_sof_r     <= RX_SOF;
      tx_eof_r     <= RX_EOF && !need_flush_s;
      tx_eof_pos_r <= eof_sum_s[EW-1:0];
      tx_src_rdy_r <= 1'b1;
      s_r          <= shift_s;
      carry_r      <= carry_nxt_s;
      flush_pos_r  <= eof_sum_s[EW-1:0];
    end else if (state_r == ST_FLUSH && out_free_s) begin
      tx_data_r    <= {{(DW-CW){1'b0}}, carry_r};
      tx_sof_r     <= 1'b0;
      tx_eof_r     <= 1'b1;
      tx_eof_pos_r <= flush_pos_r;
      tx_src_rdy_r <= 1'b1;
    end else if (out_free_s) begin
      tx_src_rdy_r <= 1'b0;
    end else begin
      tx_src_rdy_r <= tx_src_rdy_r;
    end
  end

  assign RX_DST_RDY = rx_dst_rdy_s;
  assign TX_DATA    = tx_data_r;
  assign TX_SOF     = tx_sof_r;
  assign TX_EOF     = tx_eof_r;
  assign TX_EOF_POS = tx_eof_pos_r;
  assign TX_SRC_RDY = tx_src_rdy_r;

`ifdef PTC_HDR_INSERTER_FRAME_CNT_EN
  logic [31:0] frame_cnt_r;

  // Count frame ends accepted by the sink; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RESET)                                      frame_cnt_r <= 32'd0;
    else if (tx_src_rdy_r && TX_DST_RDY && tx_eof_r) frame_cnt_r <= frame_cnt_r + 32'd1;
    else                                            frame_cnt_r <= frame_cnt_r;
  end

  assign FRAME_CNT = frame_cnt_r;
`endif

endmodule

// File: tb/tb_ptc_hdr_inserter_upto96bits.sv
// Randomized scoreboard bench for ptc_hdr_inserter_upto96bits: the expected TX stream of a frame
// is the header items followed by the payload items, packed BLOCK_SIZE items per beat.
module tb_ptc_hdr_inserter_upto96bits;
  localparam int BS = 8;
  localparam int IW = 32;
  localparam int DW = BS*IW;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [DW-1:0] RX_DATA = '0;
  logic          RX_SOF = 1'b0, RX_EOF = 1'b0;
  logic [2:0]    RX_EOF_POS = 3'd0;
  logic [95:0]   RX_HDR_DATA = '0;
  logic [1:0]    RX_HDR_LEN = 2'd0;
  logic          RX_SRC_RDY = 1'b0;
  logic          RX_DST_RDY;
  logic [DW-1:0] TX_DATA;
  logic          TX_SOF, TX_EOF;
  logic [2:0]    TX_EOF_POS;
  logic          TX_SRC_RDY;
  logic          TX_DST_RDY = 1'b1;
`ifdef PTC_HDR_INSERTER_FRAME_CNT_EN
  logic [31:0]   FRAME_CNT;
`endif

  ptc_hdr_inserter_upto96bits #(.BLOCK_SIZE(BS), .ITEM_WIDTH(IW)) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_SOF(RX_SOF), .RX_EOF(RX_EOF), .RX_EOF_POS(RX_EOF_POS),
    .RX_HDR_DATA(RX_HDR_DATA), .RX_HDR_LEN(RX_HDR_LEN),
    .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF), .TX_EOF_POS(TX_EOF_POS),
    .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
`ifdef PTC_HDR_INSERTER_FRAME_CNT_EN
    , .FRAME_CNT(FRAME_CNT)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            nvalid;
    logic          sof;
    logic          eof;
    logic [2:0]    pos;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;
  int    exp_frames = 0;

  initial forever #5 CLK = ~CLK;

  // Sink readiness: 0 = always ready, 1 = random 50%, 2 = never ready.
  initial forever begin
    @(posedge CLK);
    #2;
    case (rdy_mode)
      0:       TX_DST_RDY = 1'b1;
      1:       TX_DST_RDY = 1'($urandom_range(0, 1));
      default: TX_DST_RDY = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every TX transfer against the scoreboard and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [4:0]    prev_ctrl;
  initial forever begin
    beat_t b;
    logic [DW-1:0] a, e;
    bit bad;
    @(negedge CLK);
    if (RESET) begin
      prev_stall = 1'b0;
      exp_frames = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_data", TX_DATA, prev_data);
        chk("stall_ctrl", DW'({TX_SOF, TX_EOF, TX_EOF_POS}), DW'(prev_ctrl));
        chk("stall_valid", DW'(TX_SRC_RDY), DW'(1'b1));
      end
      if (TX_SRC_RDY && TX_DST_RDY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data %0h with nothing expected", TX_DATA);
        end else begin
          b = exp_q.pop_front();
          chk("tx_sof", DW'(TX_SOF), DW'(b.sof));
          chk("tx_eof", DW'(TX_EOF), DW'(b.eof));
          if (b.eof) begin
            chk("tx_eof_pos", DW'(TX_EOF_POS), DW'(b.pos));
            exp_frames++;
          end
          a = TX_DATA;
          e = b.data;
          bad = 1'b0;
          for (int i = 0; i < BS; i++) begin
            if (i < b.nvalid && a[IW-1:0] !== e[IW-1:0]) bad = 1'b1;
            a = a >> IW;
            e = e >> IW;
          end
          checks++;
          if (bad) begin
            failures++;
            $display("FAIL tx_data: got %0h expected %0h (items 0..%0d)", TX_DATA, b.data, b.nvalid - 1);
          end
        end
      end
      prev_stall = TX_SRC_RDY && !TX_DST_RDY;
      prev_data  = TX_DATA;
      prev_ctrl  = {TX_SOF, TX_EOF, TX_EOF_POS};
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic sof, input logic eof,
                           input logic [2:0] pos, input logic [95:0] hdr, input logic [1:0] hl);
    int waited;
    bit done;
    RX_DATA = d; RX_SOF = sof; RX_EOF = eof; RX_EOF_POS = pos;
    RX_HDR_DATA = hdr; RX_HDR_LEN = hl; RX_SRC_RDY = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (RX_DST_RDY) done = 1'b1;
      else begin
        waited++;
        if (waited > 200) begin
          checks++;
          failures++;
          $display("FAIL rx_handshake_timeout: got no RX_DST_RDY within %0d cycles, required 1", waited);
          done = 1'b1;
        end
      end
      @(posedge CLK);
      #1;
    end
    RX_SRC_RDY = 1'b0;
  endtask

  task automatic send_frame(input int hlen, input int nwords, input int lastpos, input int gap_max);
    logic [IW-1:0] hi[3];
    logic [IW-1:0] all[$];
    logic [IW-1:0] pay[$];
    logic [IW-1:0] it;
    logic [95:0]   hdr;
    logic [DW-1:0] w;
    beat_t         b;
    int            len, nb, npay;
    for (int h = 0; h < 3; h++) hi[h] = $urandom;
    hdr = {hi[2], hi[1], hi[0]};
    for (int h = 0; h < hlen; h++) all.push_back(hi[h]);
    npay = (nwords - 1)*BS + lastpos + 1;
    for (int n = 0; n < npay; n++) begin
      pay.push_back($urandom);
      all.push_back(pay[n]);
    end
    len = all.size();
    nb = (len + BS - 1)/BS;
    for (int bi = 0; bi < nb; bi++) begin
      b.nvalid = (bi == nb - 1) ? len - bi*BS : BS;
      w = '0;
      for (int i = BS - 1; i >= 0; i--) begin
        if (i < b.nvalid) it = all[bi*BS + i];
        else              it = '0;
        w = {w[DW-IW-1:0], it};
      end
      b.data = w;
      b.sof  = (bi == 0);
      b.eof  = (bi == nb - 1);
      b.pos  = 3'(b.nvalid - 1);
      exp_q.push_back(b);
    end
    for (int wi = 0; wi < nwords; wi++) begin
      repeat ($urandom_range(0, gap_max)) begin
        RX_DATA = {8{$urandom}}; RX_SOF = 1'($urandom); RX_EOF = 1'($urandom);
        RX_HDR_LEN = 2'($urandom);
        @(posedge CLK);
        #1;
      end
      w = '0;
      for (int i = BS - 1; i >= 0; i--) begin
        if (wi*BS + i < npay) it = pay[wi*BS + i];
        else                  it = $urandom;
        w = {w[DW-IW-1:0], it};
      end
      send_word(w, wi == 0, wi == nwords - 1,
                (wi == nwords - 1) ? 3'(lastpos) : 3'($urandom),
                (wi == 0) ? hdr : {$urandom, $urandom, $urandom},
                (wi == 0) ? 2'(hlen) : 2'($urandom));
    end
    if (lastpos + hlen >= BS) begin
      @(negedge CLK);
      chk("flush_blocks_rx", DW'(RX_DST_RDY), DW'(1'b0));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tx_src_rdy", DW'(TX_SRC_RDY), DW'(1'b0));
    chk("reset_tx_sof", DW'(TX_SOF), DW'(1'b0));
    chk("reset_tx_eof", DW'(TX_EOF), DW'(1'b0));
    chk("reset_tx_eof_pos", DW'(TX_EOF_POS), DW'(3'd0));
    chk("reset_tx_data", TX_DATA, {DW{1'b0}});
    RESET = 1'b0;
    @(negedge CLK);
    chk("rx_rdy_after_reset", DW'(RX_DST_RDY), DW'(1'b1));
    @(posedge CLK);
    #1;

    rdy_mode = 0;
    send_frame(3, 1, 3, 0);
    send_frame(2, 1, 6, 0);
    send_frame(1, 3, 7, 0);
    drain();

    rdy_mode = 1;
    repeat (25) send_frame(0, $urandom_range(1, 3), $urandom_range(0, 7), 2);
    drain();
    repeat (40) send_frame($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 7), 2);
    drain();

    // Reset while a flush is pending and the sink is stalled.
    rdy_mode = 2;
    send_frame(2, 1, 6, 0);
    RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    chk("reset_in_flush_valid", DW'(TX_SRC_RDY), DW'(1'b0));
    RESET = 1'b0;
    @(negedge CLK);
    chk("rx_rdy_after_flush_reset", DW'(RX_DST_RDY), DW'(1'b1));
    rdy_mode = 0;
    @(posedge CLK);
    #1;

    send_frame(3, 2, 5, 1);
    send_frame(2, 1, 6, 0);
    send_frame(0, 1, 3, 0);
    send_frame(1, 2, 2, 0);
    send_frame(3, 1, 0, 0);
    drain();

`ifdef PTC_HDR_INSERTER_FRAME_CNT_EN
    chk("frame_cnt_five", DW'(FRAME_CNT), DW'(32'd5));
    chk("frame_cnt_model", DW'(FRAME_CNT), DW'(exp_frames));
    force dut.frame_cnt_r = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    release dut.frame_cnt_r;
    send_frame(2, 1, 6, 0);
    drain();
    chk("frame_cnt_wrap", DW'(FRAME_CNT), DW'(32'd0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
